// File: rtl/adder_pipelined_nstage_pkg.sv
// Shared helpers for the pipelined adder: slice width derivation and parameter legality.
// No state; elaboration-time only.
package adder_pkg;

    function automatic int slice_width(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic bit params_ok(input int width, input int stages);
        return (width >= 2) && (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_pipelined_nstage_if.sv
// Operand/result bundle of the pipelined adder; master drives operations, slave returns results.
// Latency and stall behaviour are properties of the consumer, not of this bundle.
interface adder_pipelined_nstage_if #(
    parameter int WIDTH = 16
);
    logic             en;
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output en, in_valid, a, b, cin, sub,
        input  out_valid, sum, cout, ovf
    );

    modport slave (
        input  en, in_valid, a, b, cin, sub,
        output out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/adder_pipelined_nstage_slice.sv
// One registered SW-bit carry-chain slice: {co,s} <= a + b + cin.
// Latency 1; en=0 holds both outputs.
module adder_slice #(
    parameter int SW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] s,
    output logic          co
);
    always_ff @(posedge clk) begin
        if (rst) begin
            s  <= '0;
            co <= 1'b0;
        end else if (en) begin
            {co, s} <= {1'b0, a} + {1'b0, b} + (SW + 1)'(cin);
        end
    end
endmodule

// File: rtl/adder_pipelined_nstage.sv
// Pipelined add/sub split into STAGES carry slices with operand skew and result deskew.
// Latency STAGES, 1 op/cycle; en=0 freezes the whole pipeline (no backpressure otherwise).
module adder_pipelined_nstage
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    adder_pipelined_nstage_if.slave bus
);
    localparam int SW = slice_width(WIDTH, STAGES);

    if (!params_ok(WIDTH, STAGES)) begin : g_param_check
        $fatal(1, "adder_pipelined_nstage: WIDTH must be >= 2 and a multiple of STAGES");
    end

    logic [WIDTH-1:0]  b_eff;
    logic [STAGES:0]   carry;
    logic [WIDTH-1:0]  sum_q;
    logic [STAGES-1:0] vld_sr;
    logic [STAGES-1:0] amsb_sr;
    logic [STAGES-1:0] bmsb_sr;

    // Mode is folded into the operand here, so it travels with the data through the skew.
    assign b_eff    = bus.sub ? ~bus.b : bus.b;
    assign carry[0] = bus.sub | bus.cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int D = STAGES - 1 - k;
        logic [SW-1:0] sa;
        logic [SW-1:0] sb;
        logic [SW-1:0] ss;

        if (k == 0) begin : g_noskew
            assign sa = bus.a[0 +: SW];
            assign sb = b_eff[0 +: SW];
        end else begin : g_skew
            logic [SW-1:0] ra [k];
            logic [SW-1:0] rb [k];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int j = 0; j < k; j++) begin
                        ra[j] <= '0;
                        rb[j] <= '0;
                    end
                end else if (bus.en) begin
                    ra[0] <= bus.a[k*SW +: SW];
                    rb[0] <= b_eff[k*SW +: SW];
                    for (int j = 1; j < k; j++) begin
                        ra[j] <= ra[j-1];
                        rb[j] <= rb[j-1];
                    end
                end
            end
            assign sa = ra[k-1];
            assign sb = rb[k-1];
        end

        adder_slice #(.SW(SW)) u_slice (
            .clk (clk),
            .rst (rst),
            .en  (bus.en),
            .a   (sa),
            .b   (sb),
            .cin (carry[k]),
            .s   (ss),
            .co  (carry[k+1])
        );

        if (D == 0) begin : g_nodeskew
            assign sum_q[k*SW +: SW] = ss;
        end else begin : g_deskew
            logic [SW-1:0] rs [D];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int j = 0; j < D; j++) rs[j] <= '0;
                end else if (bus.en) begin
                    rs[0] <= ss;
                    for (int j = 1; j < D; j++) rs[j] <= rs[j-1];
                end
            end
            assign sum_q[k*SW +: SW] = rs[D-1];
        end
    end

    // Valid and the operand sign bits ride a STAGES-deep line so they meet the final sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr  <= '0;
            amsb_sr <= '0;
            bmsb_sr <= '0;
        end else if (bus.en) begin
            vld_sr  <= (vld_sr  << 1) | STAGES'(bus.in_valid);
            amsb_sr <= (amsb_sr << 1) | STAGES'(bus.a[WIDTH-1]);
            bmsb_sr <= (bmsb_sr << 1) | STAGES'(b_eff[WIDTH-1]);
        end
    end

    assign bus.out_valid = vld_sr[STAGES-1];
    assign bus.sum       = sum_q;
    assign bus.cout      = carry[STAGES];
    assign bus.ovf       = (amsb_sr[STAGES-1] == bmsb_sr[STAGES-1]) &&
                           (sum_q[WIDTH-1] != amsb_sr[STAGES-1]);
endmodule

// File: doc/adder_pipelined_nstage.md
Name: adder_pipelined_nstage

Overview:
Parametrised pipelined adder/subtractor that supersedes the fixed 8-bit two-stage adder. The carry chain is split into STAGES equal slices, with one register boundary per slice. The block adds an input-valid/output-valid qualifier, a global stall enable, a carry-in, a subtract mode and a signed-overflow flag. It serves as the arithmetic datapath element for wider accumulators and ALU front-ends, and accepts one operation per clock.

Parameters:
WIDTH, 16, operand/result width in bits; must be divisible by STAGES; minimum 2.
STAGES, 2, number of carry-chain slices (= pipeline registers = latency); 1..WIDTH.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
en  input  1  pipeline enable; 0 = whole pipeline holds.
in_valid  input  1  a/b/cin/sub are a valid operation this cycle.
a  input  WIDTH  operand A (unsigned or two's complement).
b  input  WIDTH  operand B.
cin  input  1  carry-in for add mode; ignored when sub=1.
sub  input  1  0 = a+b+cin; 1 = a-b (a + ~b + 1).
out_valid  output  1  sum/cout/ovf hold a completed result.
sum  output  WIDTH  result bits.
cout  output  1  carry out of MSB (in sub mode, 1 = no borrow).
ovf  output  1  two's-complement overflow.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - Sampled rst=1 clears every pipeline register, including skew/deskew registers and valid bits.
  - out_valid=0, sum=0, cout=0, ovf=0 from the following edge.
  - rst has priority over en.
- Slicing:
  - SW = WIDTH/STAGES.
  - Stage k (0-based) adds bits [k*SW +: SW] of a and b_eff, plus the registered carry out of stage k-1.
  - Stage 0 uses c0.
- Mode:
  - b_eff = sub ? ~b : b.
  - c0 = sub ? 1 : cin.
  - The mode is captured at input and travels with the operands; there are no mixed-mode results.
- Skew: operand slice k is delayed k registers before its adder, so it meets its carry.
- Deskew: result slice k is delayed STAGES-1-k registers after its adder, so all slices emerge aligned.
- Latency and throughput:
  - With en=1 every cycle, an operation presented at edge N appears on the outputs after edge N+STAGES.
  - Throughput is 1 op/cycle with no bubbles.
- Flags:
  - cout = carry out of the top slice.
  - ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]), evaluated with a[MSB] and b_eff[MSB] piped alongside the data.
- Valid:
  - in_valid propagates through a STAGES-deep shift register and emerges as out_valid.
  - Data registers still load when in_valid=0 (don't-care data).
  - sum/cout/ovf are only meaningful when out_valid=1.
- Stall:
  - en=0 freezes every register, including valid bits, so outputs hold their previous values.
  - Inputs presented during en=0 are discarded.
  - No result is lost or duplicated across a stall of any length.
- Reset mid-operation: all in-flight operations are dropped. out_valid stays 0 until a new operation has travelled STAGES cycles.
- STAGES=1 degenerates to a single registered full-width adder with latency 1 and no skew/deskew registers.
- Width rules: all arithmetic is modulo 2^WIDTH. There is no sign extension; the carry is exported only via cout.

Decomposition:
- Shared include/package adder_pkg holds:
  - the SW derivation (localparam function);
  - an elaboration check that WIDTH % STAGES == 0, which triggers a fatal error otherwise.
  - No typedefs are needed.
- One sub-module, adder_slice: a registered SW-bit adder with inputs a, b, cin, en, rst and registered outputs s, co. It is instantiated STAGES times in a generate loop.
- Skew/deskew delay lines are generated in the top module.

Test Plan:
- Cross-slice carry, WIDTH=16, STAGES=2: a=0xFFFF, b=0x0001, cin=0, sub=0 -> 2 cycles later sum=0x0000, cout=1, ovf=0, out_valid=1 for exactly one cycle.
- Subtract mode:
  - 0x0005-0x0007 -> sum=0xFFFE, cout=0, ovf=0.
  - 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1.
  - cin=1 is ignored in both cases.
- Streaming: all 256 combinations of a,b in 0..15, one per cycle with in_valid=1 -> 256 consecutive out_valid cycles, each matching the reference model (a+b) after 2 cycles.
- Stall: en=0 for 3 cycles mid-stream, with inputs toggling during the stall -> outputs frozen for 3 cycles; the resumed sequence has no gaps, duplicates or captured stall-time inputs.
- Reset mid-stream: rst=1 for 1 cycle with 2 ops in flight -> out_valid=0, sum=0 after the reset edge; the next output is the first op issued after reset, STAGES cycles later.
- Parameter sweep:
  - WIDTH=32, STAGES=4: 0x7FFFFFFF+0x00000001 -> 0x80000000, ovf=1, latency 4.
  - WIDTH=8, STAGES=1: 0xFF+0xFF+cin=1 -> 0xFF, cout=1, latency 1.
